// File: rtl/nand_equiv_pkg.sv
// Purpose: shared definitions for the NAND equivalence sweep engine (op codes, FSM states, widths).
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Contents: OP_AND..OP_BUF function codes, state_e FSM encoding, and cnt_width(),
// which returns the sweep counter width (two operands of W bits each).
// The optional fault-injection port on the top is enabled by NAND_EQUIV_FAULT_INJ_EN.
package nand_equiv_pkg;

    // Function select encoding, bitwise over the operand width.
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The sweep counter holds {a, b}, so it is twice the operand width.
    function automatic int cnt_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/nand_net.sv
// Purpose: structural NAND-only realisation of the eight bitwise functions plus op select.
// Latency: combinational, zero cycles.
// Backpressure: none; pure combinational network.
//
// Ports: a, b   (W-bit operands)
//        op     (3-bit function select, OP_* encoding)
//        y      (W-bit result of the selected function)
module nand_net
    import nand_equiv_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] y
);

    wire [2:0]   op_n;
    wire [7:0]   sel_n;
    wire [7:0]   sel;
    wire [W-1:0] y_w;

    // Op decoder built from NANDs: sel is one-hot on the selected function.
    for (genvar j = 0; j < 3; j++) begin : g_inv
        nand u_inv (op_n[j], op[j], op[j]);
    end

    for (genvar k = 0; k < 8; k++) begin : g_dec
        wire [2:0] lit;
        for (genvar j = 0; j < 3; j++) begin : g_lit
            if (((k >> j) & 1) != 0) begin : g_pos
                assign lit[j] = op[j];
            end else begin : g_neg
                assign lit[j] = op_n[j];
            end
        end
        nand u_dec (sel_n[k], lit[0], lit[1], lit[2]);
        nand u_sel (sel[k], sel_n[k], sel_n[k]);
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        wire       n_ab;
        wire       n_aa;
        wire       n_bb;
        wire       f_and;
        wire       f_or;
        wire       f_nor;
        wire       x_l;
        wire       x_r;
        wire       f_xor;
        wire       f_xnor;
        wire       f_buf;
        wire [7:0] fn;
        wire [7:0] term;

        // Every function derived from two-input NANDs.
        nand u_ab   (n_ab,   a[i],  b[i]);
        nand u_and  (f_and,  n_ab,  n_ab);
        nand u_aa   (n_aa,   a[i],  a[i]);
        nand u_bb   (n_bb,   b[i],  b[i]);
        nand u_or   (f_or,   n_aa,  n_bb);
        nand u_nor  (f_nor,  f_or,  f_or);
        // Classic four-NAND XOR sharing the a/b NAND.
        nand u_xl   (x_l,    a[i],  n_ab);
        nand u_xr   (x_r,    b[i],  n_ab);
        nand u_xor  (f_xor,  x_l,   x_r);
        nand u_xnor (f_xnor, f_xor, f_xor);
        nand u_buf  (f_buf,  n_aa,  n_aa);

        assign fn[OP_AND]  = f_and;
        assign fn[OP_OR]   = f_or;
        assign fn[OP_NAND] = n_ab;
        assign fn[OP_NOR]  = f_nor;
        assign fn[OP_XOR]  = f_xor;
        assign fn[OP_XNOR] = f_xnor;
        assign fn[OP_NOT]  = n_aa;
        assign fn[OP_BUF]  = f_buf;

        // AND-OR mux as NAND-NAND: y = ~&(~(fn & sel)) = |(fn & sel).
        for (genvar k = 0; k < 8; k++) begin : g_term
            nand u_term (term[k], fn[k], sel[k]);
        end
        nand u_out (y_w[i], term[0], term[1], term[2], term[3],
                            term[4], term[5], term[6], term[7]);
    end

    assign y = y_w;

endmodule

// File: rtl/nand_equiv_checker.sv
// Purpose: exhaustive sweep comparing the NAND network against the behavioural expression.
// Latency: start accepted at edge k -> done asserted after edge k + 2^(2W).
// Backpressure: none; start is only sampled in IDLE/DONE, ignored while a sweep runs.
//
// Ports: clk, rst_n (async active-low), start, op[2:0] (latched on accepted start),
//        busy, done, pass, mism_cnt[2W:0], vec_a/vec_b (current vector),
//        res_nand/res_expr (both results for the current vector).
// Option: NAND_EQUIV_FAULT_INJ_EN adds input inj (latched on start); when set, bit 0
//         of res_nand is inverted whenever vec_a == vec_b.
module nand_equiv_checker
    import nand_equiv_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef NAND_EQUIV_FAULT_INJ_EN
    input  logic           inj,
`endif
    input  logic           start,
    input  logic [2:0]     op,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   mism_cnt,
    output logic [W-1:0]   vec_a,
    output logic [W-1:0]   vec_b,
    output logic [W-1:0]   res_nand,
    output logic [W-1:0]   res_expr
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]   MISM_ONE = {{CW{1'b0}}, 1'b1};

    state_e        state_q;
    state_e        state_d;
    logic [2:0]    op_q;
    logic [2:0]    op_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW:0]   mism_q;
    logic [CW:0]   mism_d;

    logic [W-1:0]  net_y;
    logic [W-1:0]  nand_y;
    logic [W-1:0]  expr_y;
    logic          mismatch;

    // The counter is the applied vector: a in the upper half, b in the lower.
    assign vec_a = cnt_q[CW-1:W];
    assign vec_b = cnt_q[W-1:0];

    nand_net #(
        .W (W)
    ) u_net (
        .a  (vec_a),
        .b  (vec_b),
        .op (op_q),
        .y  (net_y)
    );

`ifdef NAND_EQUIV_FAULT_INJ_EN
    logic         inj_q;
    logic         inj_d;
    logic [W-1:0] fault_mask;

    // Diagonal vectors (a == b) number exactly 2^W, so a known mismatch count results.
    always_comb begin
        fault_mask    = '0;
        fault_mask[0] = inj_q && (vec_a == vec_b);
    end

    assign nand_y = net_y ^ fault_mask;
`else
    assign nand_y = net_y;
`endif

    // Behavioural reference for the latched function.
    always_comb begin
        expr_y = '0;
        case (op_q)
            OP_AND:  expr_y = vec_a & vec_b;
            OP_OR:   expr_y = vec_a | vec_b;
            OP_NAND: expr_y = ~(vec_a & vec_b);
            OP_NOR:  expr_y = ~(vec_a | vec_b);
            OP_XOR:  expr_y = vec_a ^ vec_b;
            OP_XNOR: expr_y = ~(vec_a ^ vec_b);
            OP_NOT:  expr_y = ~vec_a;
            OP_BUF:  expr_y = vec_a;
            default: expr_y = '0;
        endcase
    end

    assign mismatch = (nand_y != expr_y);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        mism_d  = mism_q;
`ifdef NAND_EQUIV_FAULT_INJ_EN
        inj_d   = inj_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    op_d    = op;
                    cnt_d   = '0;
                    mism_d  = '0;
`ifdef NAND_EQUIV_FAULT_INJ_EN
                    inj_d   = inj;
`endif
                end
            end
            ST_RUN: begin
                // The vector visible before this edge is scored, including the last one.
                if (mismatch) begin
                    mism_d = mism_q + MISM_ONE;
                end
                // Counter parks on all-ones in DONE so it never wraps.
                if (&cnt_q) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_AND;
            cnt_q   <= '0;
            mism_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            mism_q  <= mism_d;
        end
    end

`ifdef NAND_EQUIV_FAULT_INJ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_q <= 1'b0;
        end else begin
            inj_q <= inj_d;
        end
    end
`endif

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign pass     = (state_q == ST_DONE) && (mism_q == '0);
    assign mism_cnt = mism_q;
    assign res_nand = nand_y;
    assign res_expr = expr_y;

endmodule

// File: tb/tb_nand_equiv_checker.sv
`timescale 1ns/1ps
module tb_nand_equiv_checker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Three instances: index 0 -> W=1, 1 -> W=2, 2 -> W=4.
    logic [2:0]       start_x;
    logic [2:0][2:0]  op_x;
`ifdef NAND_EQUIV_FAULT_INJ_EN
    logic [2:0]       inj_x;
`endif
    logic [2:0]       busy_x;
    logic [2:0]       done_x;
    logic [2:0]       pass_x;
    logic [2:0][7:0]  va_x;
    logic [2:0][7:0]  vb_x;
    logic [2:0][7:0]  rn_x;
    logic [2:0][7:0]  re_x;
    logic [2:0][16:0] mc_x;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WI = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [WI-1:0] va;
        logic [WI-1:0] vb;
        logic [WI-1:0] rn;
        logic [WI-1:0] re;
        logic [2*WI:0] mc;

        nand_equiv_checker #(
            .W (WI)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
`ifdef NAND_EQUIV_FAULT_INJ_EN
            .inj      (inj_x[g]),
`endif
            .start    (start_x[g]),
            .op       (op_x[g]),
            .busy     (busy_x[g]),
            .done     (done_x[g]),
            .pass     (pass_x[g]),
            .mism_cnt (mc),
            .vec_a    (va),
            .vec_b    (vb),
            .res_nand (rn),
            .res_expr (re)
        );

        assign va_x[g] = 8'(va);
        assign vb_x[g] = 8'(vb);
        assign rn_x[g] = 8'(rn);
        assign re_x[g] = 8'(re);
        assign mc_x[g] = 17'(mc);
    end

    typedef struct packed {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] rn;
        logic [7:0] re;
    } vexp_t;

    typedef struct packed {
        logic [16:0] mc;
        logic        ps;
    } rexp_t;

    vexp_t vq[$];
    rexp_t rq[$];

    int total  = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] model(input logic [2:0] f, input logic [7:0] a,
                                         input logic [7:0] b, input int w);
        logic [7:0] r;
        logic [7:0] m;
        m = 8'((1 << w) - 1);
        case (f)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = ~(a & b);
            3'd3:    r = ~(a | b);
            3'd4:    r = a ^ b;
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = a;
        endcase
        return r & m;
    endfunction

    // Full sweep on instance d: expectations are queued up front, then popped per cycle.
    task automatic run_sweep(input int d, input int w, input logic [2:0] f,
                             input logic inj, input bit hold_toggle);
        int         nv;
        logic [7:0] m;
        vexp_t      e;
        rexp_t      r;
        nv = 1 << (2 * w);
        m  = 8'((1 << w) - 1);
        for (int n = 0; n < nv; n++) begin
            e.va = 8'(n >> w) & m;
            e.vb = 8'(n) & m;
            e.re = model(f, e.va, e.vb, w);
            e.rn = e.re ^ {7'd0, (inj && (e.va == e.vb))};
            vq.push_back(e);
        end
        r.mc = inj ? 17'(1 << w) : 17'd0;
        r.ps = !inj;
        rq.push_back(r);

        @(negedge clk);
        start_x[d] = 1'b1;
        op_x[d]    = f;
`ifdef NAND_EQUIV_FAULT_INJ_EN
        inj_x[d]   = inj;
`endif
        @(negedge clk);
        if (!hold_toggle) begin
            start_x[d] = 1'b0;
            op_x[d]    = ~f;
        end
        for (int n = 0; n < nv; n++) begin
            e = vq.pop_front();
            check($sformatf("d%0d op%0d n%0d busy_done", d, f, n), {busy_x[d], done_x[d]}, 2'b10);
            check($sformatf("d%0d op%0d n%0d vec", d, f, n), {va_x[d], vb_x[d]}, {e.va, e.vb});
            check($sformatf("d%0d op%0d n%0d res_nand", d, f, n), rn_x[d], e.rn);
            check($sformatf("d%0d op%0d n%0d res_expr", d, f, n), re_x[d], e.re);
            if (hold_toggle) begin
                op_x[d] = 3'($urandom_range(0, 7));
            end
            @(negedge clk);
        end
        r = rq.pop_front();
        check($sformatf("d%0d op%0d end busy_done", d, f), {busy_x[d], done_x[d]}, 2'b01);
        check($sformatf("d%0d op%0d end mism_cnt", d, f), mc_x[d], r.mc);
        check($sformatf("d%0d op%0d end pass", d, f), pass_x[d], r.ps);
        start_x[d] = 1'b0;
    endtask

    task automatic check_zero(input string tag, input int d);
        check({tag, " busy"}, busy_x[d], 1'b0);
        check({tag, " done"}, done_x[d], 1'b0);
        check({tag, " pass"}, pass_x[d], 1'b0);
        check({tag, " mism_cnt"}, mc_x[d], 17'd0);
        check({tag, " vec"}, {va_x[d], vb_x[d]}, 16'd0);
        check({tag, " res"}, {rn_x[d], re_x[d]}, 16'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_x = '0;
        op_x    = '0;
`ifdef NAND_EQUIV_FAULT_INJ_EN
        inj_x   = '0;
`endif
        #2;
        for (int d = 0; d < 3; d++) begin
            check_zero($sformatf("reset d%0d", d), d);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // W=2 AND, then done must hold while start stays low.
        run_sweep(1, 2, 3'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("w2 done held", {busy_x[1], done_x[1], pass_x[1]}, 3'b011);
        check("w2 mism held", mc_x[1], 17'd0);

        // W=4, every op back to back; later sweeps restart from DONE.
        for (int f = 0; f < 8; f++) begin
            run_sweep(2, 4, 3'(f), 1'b0, 1'b0);
        end

        // W=2, start held and op toggling through the run.
        run_sweep(1, 2, 3'd2, 1'b0, 1'b1);

        // W=2, asynchronous reset in the middle of a sweep.
        @(negedge clk);
        start_x[1] = 1'b1;
        op_x[1]    = 3'd4;
        @(negedge clk);
        start_x[1] = 1'b0;
        repeat (7) @(negedge clk);
        check("mid busy", busy_x[1], 1'b1);
        check("mid vec", {va_x[1], vb_x[1]}, {8'd1, 8'd3});
        #1 rst_n = 1'b0;
        #1;
        check_zero("mid reset", 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(1, 2, 3'd4, 1'b0, 1'b0);

`ifdef NAND_EQUIV_FAULT_INJ_EN
        run_sweep(1, 2, 3'd4, 1'b1, 1'b0);
        run_sweep(1, 2, 3'd4, 1'b0, 1'b0);
`endif

        // W=1, NOT a: vectors 00,01,10,11.
        run_sweep(0, 1, 3'd6, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
